pipeline_hazard_ctrl: RTL and testbench

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/pipeline_hazard_ctrl.sv | 176 +++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Hazard / freeze / flush controller for a five-stage in-order pipeline.
// Keeps shadow copies of the EXE and MEM stage control fields. From them and
// the instruction in ID it decides whether ID must stall (data hazard),
// whether the whole pipeline must freeze (data memory wait), and whether
// IF/ID must be squashed (taken branch).
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous, active-high reset
//   id_valid       ID holds a real instruction (0 = bubble)
//   src1, src2     ID source registers
//   Two_src        src2 is a real operand
//   id_wb_en       ID instruction writes a register
//   id_mem_r_en    ID instruction is a load
//   id_mem_w_en    ID instruction is a store
//   id_dest        ID destination register
//   forward_en     forwarding unit active (quasi-static)
//   branch_taken   EXE resolved a taken branch this cycle
//   mem_ready      data memory completes the current access this cycle
//   hazard         stall IF/ID, ID issues a bubble
//   freeze         hold every pipeline register (memory wait)
//   flush          squash IF/ID contents
//   mem_req        MEM slot requests a memory access
//   state          0 = RUN, 1 = MEM_WAIT
//   stall_cnt      saturating count of cycles with hazard or freeze asserted
//
// hazard, freeze, flush and mem_req are combinational: freeze must act in the
// same cycle the memory reports it is not ready, so they cannot be delayed.
// They derive from registered slot state, so they are all 0 while reset is
// held (flush is additionally gated by rst, as branch_taken is a raw input).
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [3:0]  src1,
    input  logic [3:0]  src2,
    input  logic        Two_src,
    input  logic        id_wb_en,
    input  logic        id_mem_r_en,
    input  logic        id_mem_w_en,
    input  logic [3:0]  id_dest,
    input  logic        forward_en,
    input  logic        branch_taken,
    input  logic        mem_ready,
    output logic        hazard,
    output logic        freeze,
    output logic        flush,
    output logic        mem_req,
    output logic        state,
    output logic [15:0] stall_cnt
);

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_t;

    typedef struct packed {
        logic       valid;
        logic       wb_en;
        logic       mem_r_en;
        logic       mem_w_en;
        logic [3:0] dest;
    } slot_t;

    slot_t       exe_r;
    slot_t       mem_r;
    slot_t       id_slot_s;
    state_t      state_r;
    logic [15:0] stall_cnt_r;

    logic        exe_match_s;
    logic        mem_match_s;
    logic        hazard_raw_s;
    logic        hazard_s;
    logic        freeze_s;
    logic        flush_s;
    logic        mem_req_s;
    logic        issue_s;

    // True when a valid, register-writing slot produces a value ID reads.
    function automatic logic src_match(input slot_t slot,
                                       input logic [3:0] s1,
                                       input logic [3:0] s2,
                                       input logic two);
        return slot.valid & slot.wb_en &
               ((s1 == slot.dest) | (two & (s2 == slot.dest)));
    endfunction

    // Hazard, freeze, flush and memory request decode.
    always_comb begin
        id_slot_s    = '{valid: id_valid, wb_en: id_wb_en, mem_r_en: id_mem_r_en,
                         mem_w_en: id_mem_w_en, dest: id_dest};
        exe_match_s  = src_match(exe_r, src1, src2, Two_src);
        mem_match_s  = src_match(mem_r, src1, src2, Two_src);
        mem_req_s    = mem_r.valid & (mem_r.mem_r_en | mem_r.mem_w_en);
        freeze_s     = mem_req_s & ~mem_ready;
        flush_s      = branch_taken & ~freeze_s & ~rst;
        hazard_raw_s = 1'b0;
        if (forward_en) begin
            // Forwarding covers everything except a load feeding the next op.
            hazard_raw_s = id_valid & exe_match_s & exe_r.mem_r_en;
        end else begin
            hazard_raw_s = id_valid & (exe_match_s | mem_match_s);
        end
        // A flush squashes the ID instruction anyway, and a freeze holds it.
        hazard_s     = hazard_raw_s & ~flush_s & ~freeze_s & ~rst;
        issue_s      = id_valid & ~hazard_s & ~flush_s;
    end

    // EXE and MEM shadow slots advance unless the pipeline is frozen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exe_r <= '0;
            mem_r <= '0;
        end else if (!freeze_s) begin
            mem_r <= exe_r;
            if (issue_s) begin
                exe_r <= id_slot_s;
            end else begin
                exe_r <= '0;
            end
        end else begin
            exe_r <= exe_r;
            mem_r <= mem_r;
        end
    end

    // RUN / MEM_WAIT tracker; a single-cycle access never raises freeze.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_RUN;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (freeze_s) begin
                        state_r <= ST_MEM_WAIT;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_MEM_WAIT: begin
                    if (mem_ready) begin
                        state_r <= ST_RUN;
                    end else begin
                        state_r <= ST_MEM_WAIT;
                    end
                end
                default: state_r <= ST_RUN;
            endcase
        end
    end

    // Saturating stall cycle counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_r <= 16'h0000;
        end else if ((hazard_s | freeze_s) && (stall_cnt_r != 16'hFFFF)) begin
            stall_cnt_r <= stall_cnt_r + 16'h0001;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign hazard    = hazard_s;
    assign freeze    = freeze_s;
    assign flush     = flush_s;
    assign mem_req   = mem_req_s;
    assign state     = state_r;
    assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for pipeline_hazard_ctrl. Directed vectors are applied one cycle
// at a time; each vector pushes its hand-computed expected outputs, tagged with
// the cycle number, into a queue. A separate monitor samples the DUT on the
// falling edge and compares against the queued entries for that cycle.
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [3:0]  src1;
    logic [3:0]  src2;
    logic        Two_src;
    logic        id_wb_en;
    logic        id_mem_r_en;
    logic        id_mem_w_en;
    logic [3:0]  id_dest;
    logic        forward_en;
    logic        branch_taken;
    logic        mem_ready;
    logic        hazard;
    logic        freeze;
    logic        flush;
    logic        mem_req;
    logic        state;
    logic [15:0] stall_cnt;

    typedef struct packed {
        logic [31:0] cyc;
        logic        hz;
        logic        fz;
        logic        fl;
        logic        mq;
        logic        st;
        logic [15:0] cnt;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    cyc      = 0;
    int    n_checks = 0;
    int    n_pass   = 0;

    pipeline_hazard_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .src1         (src1),
        .src2         (src2),
        .Two_src      (Two_src),
        .id_wb_en     (id_wb_en),
        .id_mem_r_en  (id_mem_r_en),
        .id_mem_w_en  (id_mem_w_en),
        .id_dest      (id_dest),
        .forward_en   (forward_en),
        .branch_taken (branch_taken),
        .mem_ready    (mem_ready),
        .hazard       (hazard),
        .freeze       (freeze),
        .flush        (flush),
        .mem_req      (mem_req),
        .state        (state),
        .stall_cnt    (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter used to tag expectations.
    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    // Monitor: compare every expectation tagged with the current cycle.
    initial begin
        exp_t  e;
        string nm;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].cyc == 32'(cyc)) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                n_checks = n_checks + 1;
                if ({hazard, freeze, flush, mem_req, state, stall_cnt} ===
                    {e.hz, e.fz, e.fl, e.mq, e.st, e.cnt}) begin
                    n_pass = n_pass + 1;
                end else begin
                    $display("FAIL %s: got hz=%b fz=%b fl=%b mq=%b st=%b cnt=%0d, required hz=%b fz=%b fl=%b mq=%b st=%b cnt=%0d",
                             nm, hazard, freeze, flush, mem_req, state, stall_cnt,
                             e.hz, e.fz, e.fl, e.mq, e.st, e.cnt);
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #1500000;
        $display("FAIL watchdog: got still running, required finished");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [3:0] s1, input logic [3:0] s2,
                          input logic two, input logic wb, input logic mr,
                          input logic mw, input logic [3:0] d);
        id_valid    = v;
        src1        = s1;
        src2        = s2;
        Two_src     = two;
        id_wb_en    = wb;
        id_mem_r_en = mr;
        id_mem_w_en = mw;
        id_dest     = d;
    endtask

    task automatic bubble();
        set_id(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    endtask

    task automatic expect_o(input string nm, input logic hz, input logic fz,
                            input logic fl, input logic mq, input logic st,
                            input logic [15:0] cnt);
        exp_t e;
        e = '{cyc: 32'(cyc), hz: hz, fz: fz, fl: fl, mq: mq, st: st, cnt: cnt};
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    initial begin
        rst          = 1'b1;
        forward_en   = 1'b0;
        branch_taken = 1'b1;
        mem_ready    = 1'b1;
        bubble();

        // Reset state, with branch_taken high to show flush is held off.
        tick(); expect_o("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);

        // RAW without forwarding: ADD R3 then a reader of R3.
        tick(); rst = 1'b0; branch_taken = 1'b0;
        set_id(1'b1, 4'd1, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0, 4'd3);
        expect_o("add_r3_issue", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        tick(); set_id(1'b1, 4'd3, 4'd5, 1'b0, 1'b1, 1'b0, 1'b0, 4'd6);
        expect_o("raw_exe", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        tick(); expect_o("raw_mem", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1);
        tick(); expect_o("raw_clear", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2);

        // R15 matching through src2, and id_valid qualification.
        tick(); set_id(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd15);
        expect_o("r15_issue", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2);
        tick(); set_id(1'b1, 4'd1, 4'd15, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        expect_o("r15_src2", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2);
        tick(); id_valid = 1'b0;
        expect_o("id_invalid", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd3);

        // Forwarding: load-use stalls exactly one cycle.
        tick(); forward_en = 1'b1;
        set_id(1'b1, 4'd1, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd4);
        expect_o("ldr_r4_issue", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd3);
        tick(); set_id(1'b1, 4'd0, 4'd4, 1'b1, 1'b1, 1'b0, 1'b0, 4'd7);
        expect_o("load_use", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd3);
        tick(); expect_o("load_use_done", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd4);
        tick(); set_id(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd4);
        expect_o("ldr_r4_again", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd4);
        tick(); set_id(1'b1, 4'd1, 4'd4, 1'b0, 1'b1, 1'b0, 1'b0, 4'd8);
        expect_o("two_src_off", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd4);
        tick(); set_id(1'b1, 4'd8, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        expect_o("fwd_alu_single_cycle_mem", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd4);
        tick(); bubble();
        expect_o("stay_run", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd4);

        // Store held in MEM for three cycles, branch arriving during freeze.
        tick(); forward_en = 1'b0;
        set_id(1'b1, 4'd1, 4'd2, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
        expect_o("str_issue", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd4);
        tick(); set_id(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd9);
        expect_o("r9_issue", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd4);
        tick(); mem_ready = 1'b0;
        set_id(1'b1, 4'd9, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd10);
        expect_o("freeze_1", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd4);
        tick(); expect_o("freeze_2", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'd5);
        tick(); branch_taken = 1'b1;
        expect_o("freeze_3_branch", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'd6);
        tick(); mem_ready = 1'b1;
        expect_o("mem_done_flush", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'd7);
        tick(); branch_taken = 1'b0;
        set_id(1'b1, 4'd10, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        expect_o("after_flush_run", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd7);

        // Taken branch coinciding with a hazard.
        tick(); set_id(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd11);
        expect_o("add_r11_issue", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd7);
        tick(); branch_taken = 1'b1;
        set_id(1'b1, 4'd11, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd12);
        expect_o("branch_over_hazard", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd7);
        tick(); branch_taken = 1'b0;
        set_id(1'b1, 4'd12, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        expect_o("exe_bubble_after_flush", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd7);

        // Reset asserted during MEM_WAIT.
        tick(); set_id(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
        expect_o("str2_issue", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd7);
        tick(); bubble();
        expect_o("str2_to_mem", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd7);
        tick(); mem_ready = 1'b0;
        expect_o("str2_freeze_1", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd7);
        tick(); expect_o("str2_freeze_2", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'd8);
        tick(); rst = 1'b1; branch_taken = 1'b1;
        expect_o("async_reset_mem_wait", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        tick(); expect_o("reset_held", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);

        // First edges after reset behave as normal RUN.
        tick(); rst = 1'b0; branch_taken = 1'b0; mem_ready = 1'b1;
        set_id(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd3);
        expect_o("post_reset_issue", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        tick(); set_id(1'b1, 4'd3, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        expect_o("post_reset_raw_exe", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        tick(); expect_o("post_reset_raw_mem", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1);
        tick(); bubble();
        expect_o("post_reset_clear", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2);

        // Long freeze drives the counter into saturation.
        tick(); set_id(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
        expect_o("str3_issue", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2);
        tick(); bubble();
        expect_o("str3_to_mem", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2);
        for (int n = 0; n <= 70000; n++) begin
            tick(); mem_ready = 1'b0;
            if (n == 0)     expect_o("sat_start",  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd2);
            if (n == 65532) expect_o("sat_fffe",   1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'hFFFE);
            if (n == 65533) expect_o("sat_ffff",   1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'hFFFF);
            if (n == 65534) expect_o("sat_hold",   1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'hFFFF);
            if (n == 70000) expect_o("sat_70000",  1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'hFFFF);
        end
        tick(); mem_ready = 1'b1;
        expect_o("sat_release", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'hFFFF);
        tick(); expect_o("sat_back_run", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'hFFFF);

        tick();
        tick();
        n_checks = n_checks + 1;
        if (exp_q.size() == 0) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL queue_drain: got %0d pending, required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
